// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; 32 iterations, returns {remainder, quotient}.
// Holds the pipeline through busy while a division is in flight; annul aborts without a result.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sign,
   input  logic        start,
   input  logic        annul,
   output logic [63:0] result,
   output logic        ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ON      = 2'd1,
      DIVZERO = 2'd2,
      END     = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [31:0] rem_r, quo_r, dvs_r;
   logic        neg_q_r, neg_r_r;
   logic [4:0]  cnt_r;
   logic        load_s, iter_s, wr_s, wr_zero_s;
   logic [32:0] shifted_s, trial_s;
   logic [31:0] rem_next_s, quo_next_s, rem_fix_s, quo_fix_s;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? neg32(v) : v;
   endfunction

   // One restoring step; the trial difference never exceeds 32 magnitude bits, so bit 32 is its sign
   assign shifted_s  = {rem_r, quo_r[31]};
   assign trial_s    = shifted_s - {1'b0, dvs_r};
   assign rem_next_s = trial_s[32] ? shifted_s[31:0] : trial_s[31:0];
   assign quo_next_s = {quo_r[30:0], ~trial_s[32]};
   assign quo_fix_s  = neg_q_r ? neg32(quo_next_s) : quo_next_s;
   assign rem_fix_s  = neg_r_r ? neg32(rem_next_s) : rem_next_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and datapath control; annul wins over every normal transition
   always_comb begin
      state_s   = state_r;
      load_s    = 1'b0;
      iter_s    = 1'b0;
      wr_s      = 1'b0;
      wr_zero_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && !annul) begin
               load_s  = 1'b1;
               state_s = (b == 32'd0) ? DIVZERO : ON;
            end else begin
               state_s = IDLE;
            end
         end
         ON: begin
            if (annul) begin
               state_s = IDLE;
            end else begin
               iter_s = 1'b1;
               if (cnt_r == 5'd31) begin
                  state_s = END;
                  wr_s    = 1'b1;
               end else begin
                  state_s = ON;
               end
            end
         end
         DIVZERO: begin
            if (annul) begin
               state_s = IDLE;
            end else begin
               state_s   = END;
               wr_zero_s = 1'b1;
            end
         end
         END:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Operand latch and iteration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r   <= 32'd0;
         quo_r   <= 32'd0;
         dvs_r   <= 32'd0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         cnt_r   <= 5'd0;
      end else if (load_s) begin
         rem_r   <= 32'd0;
         quo_r   <= sign ? abs32(a) : a;
         dvs_r   <= sign ? abs32(b) : b;
         neg_q_r <= sign & (a[31] ^ b[31]);
         neg_r_r <= sign & a[31];
         cnt_r   <= 5'd0;
      end else if (iter_s) begin
         rem_r <= rem_next_s;
         quo_r <= quo_next_s;
         cnt_r <= cnt_r + 5'd1;
      end else begin
         rem_r <= rem_r;
         quo_r <= quo_r;
         cnt_r <= cnt_r;
      end
   end

   // Registered outputs; result holds until the next entry into END
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= 64'd0;
         ready  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         if (wr_s) begin
            result <= {rem_fix_s, quo_fix_s};
         end else if (wr_zero_s) begin
            result <= 64'd0;
         end else begin
            result <= result;
         end
         ready <= (state_s == END);
         busy  <= (state_s == ON) || (state_s == DIVZERO);
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by zero, abort and handshake.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst, sign, start, annul;
   logic [31:0] a, b;
   logic [63:0] result;
   logic        ready, busy;
   int          total = 0;
   int          bad = 0;

   div_unit dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .sign(sign), .start(start),
      .annul(annul), .result(result), .ready(ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Starts at a negedge in IDLE; returns ready latency, busy cycles and result, ends in IDLE at a negedge
   task automatic run_div(input logic [31:0] da, input logic [31:0] db, input logic ds,
                          output int lat, output int bsy, output logic [63:0] res);
      a = da; b = db; sign = ds; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 32'hDEADBEEF; b = 32'h00000003; sign = ~ds;
      lat = -1; bsy = 0; res = 64'hX;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (busy) bsy++;
         if (ready) begin
            lat = k;
            res = result;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; a = 32'd0; b = 32'd0; sign = 1'b0; start = 1'b0; annul = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
   endtask

   task automatic test_unsigned();
      int lat, bsy; logic [63:0] res;
      run_div(32'd100, 32'd7, 1'b0, lat, bsy, res);
      total++; if (lat !== 33) begin bad++; $display("FAIL unsigned_latency got=%0d want=33", lat); end
      total++; if (bsy !== 32) begin bad++; $display("FAIL unsigned_busy got=%0d want=32", bsy); end
      total++; if (res !== {32'd2, 32'd14}) begin bad++; $display("FAIL unsigned_result got=%h want=%h", res, {32'd2, 32'd14}); end
   endtask

   task automatic test_signed();
      int lat, bsy; logic [63:0] res;
      run_div(32'hFFFFFFF9, 32'd2, 1'b1, lat, bsy, res);
      total++; if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin bad++; $display("FAIL signed_neg_pos got=%h want=ffffffff_fffffffd", res); end
      run_div(32'd7, 32'hFFFFFFFE, 1'b1, lat, bsy, res);
      total++; if (res !== {32'd1, 32'hFFFFFFFD}) begin bad++; $display("FAIL signed_pos_neg got=%h want=00000001_fffffffd", res); end
      run_div(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, lat, bsy, res);
      total++; if (res !== {32'hFFFFFFFF, 32'd3}) begin bad++; $display("FAIL signed_neg_neg got=%h want=ffffffff_00000003", res); end
   endtask

   task automatic test_overflow();
      int lat, bsy; logic [63:0] res;
      run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bsy, res);
      total++; if (res !== {32'd0, 32'h80000000}) begin bad++; $display("FAIL overflow_signed got=%h want=00000000_80000000", res); end
      run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bsy, res);
      total++; if (res !== {32'h80000000, 32'd0}) begin bad++; $display("FAIL large_unsigned got=%h want=80000000_00000000", res); end
   endtask

   task automatic test_divzero();
      int lat, bsy; logic [63:0] res;
      run_div(32'd5, 32'd0, 1'b0, lat, bsy, res);
      total++; if (lat !== 2) begin bad++; $display("FAIL divzero_latency got=%0d want=2", lat); end
      total++; if (bsy !== 1) begin bad++; $display("FAIL divzero_busy got=%0d want=1", bsy); end
      total++; if (res !== 64'd0) begin bad++; $display("FAIL divzero_result got=%h want=0", res); end
   endtask

   task automatic test_abort();
      int lat, bsy, pulses; logic [63:0] res;
      run_div(32'd100, 32'd7, 1'b0, lat, bsy, res);
      a = 32'd50; b = 32'd3; sign = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(negedge clk);
      annul = 1'b1;
      @(posedge clk); #1; annul = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL annul_busy got=%b want=0", busy); end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL annul_ready got=%0d want=0", pulses); end
      total++; if (result !== {32'd2, 32'd14}) begin bad++; $display("FAIL annul_hold got=%h want=%h", result, {32'd2, 32'd14}); end
      // start together with annul in IDLE must be ignored
      start = 1'b1; annul = 1'b1;
      @(posedge clk); #1; start = 1'b0; annul = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL annul_start_busy got=%b want=0", busy); end
      // reset mid-division
      a = 32'd1000; b = 32'd9; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (19) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b want=1", busy); end
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      total++; if (result !== 64'd0) begin bad++; $display("FAIL rst_mid_result got=%h want=0", result); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b want=0", ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
   endtask

   task automatic test_back_to_back();
      int k, n, pulses; int t[2]; logic [63:0] r[2];
      a = 32'd1000; b = 32'd10; sign = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = 32'd77; b = 32'd5;
      k = 0; n = 0;
      for (int i = 0; i < 120 && n < 2; i++) begin
         @(negedge clk); k++;
         if (ready) begin t[n] = k; r[n] = result; n++; end
      end
      start = 1'b0;
      total++; if (n !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", n); end
      if (n == 2) begin
         total++; if (t[0] !== 33) begin bad++; $display("FAIL b2b_first got=%0d want=33", t[0]); end
         total++; if (t[1] - t[0] !== 34) begin bad++; $display("FAIL b2b_period got=%0d want=34", t[1] - t[0]); end
         total++; if (r[0] !== {32'd0, 32'd100}) begin bad++; $display("FAIL b2b_res0 got=%h want=%h", r[0], {32'd0, 32'd100}); end
         total++; if (r[1] !== {32'd2, 32'd15}) begin bad++; $display("FAIL b2b_res1 got=%h want=%h", r[1], {32'd2, 32'd15}); end
      end
      @(negedge clk); @(negedge clk);
      // a start pulse while busy is dropped
      a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (5) @(negedge clk);
      a = 32'd9; b = 32'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      pulses = 0; r[0] = 64'd0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (ready) begin pulses++; r[0] = result; end
      end
      total++; if (pulses !== 1) begin bad++; $display("FAIL busy_start_pulses got=%0d want=1", pulses); end
      total++; if (r[0] !== {32'd2, 32'd14}) begin bad++; $display("FAIL busy_start_result got=%h want=%h", r[0], {32'd2, 32'd14}); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow();
      test_divzero();
      test_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
